// File: rtl/board_engine.sv
// board_engine: 8x8 match-3 board with swap/scan/clear/fall/refill engine.
// Ports:
//   clk, clrn                        clock, async active-low reset
//   cmd_valid/cmd_ready              swap command handshake
//   cmd_r0/cmd_c0/cmd_r1/cmd_c1      the two cells to swap
//   wr_en/wr_row/wr_col/wr_color     direct cell write, honoured only when idle
//   rd_row/rd_col -> rd_color        registered display read, 1-cycle latency
//   rsp_valid/rsp_ok                 completion pulse, 1 = swap kept
//   busy, score                      engine active, saturating cleared-cell count
module board_engine #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MAX_CASCADE = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_r0,
  input  logic [2:0]  cmd_c0,
  input  logic [2:0]  cmd_r1,
  input  logic [2:0]  cmd_c1,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic [2:0]  wr_color,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [2:0]  rd_color,
  output logic        rsp_valid,
  output logic        rsp_ok,
  output logic        busy,
  output logic [15:0] score
);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  EMPTY     = 3'd7;

  // DONE is not a held state: the completing transition goes straight to
  // IDLE and raises the registered rsp_valid pulse for that one cycle.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_UNDO  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_FALL  = 3'd5;

  logic [2:0]            state;
  logic [7:0][7:0][2:0]  board;      // board[row][col], row 0 = top
  logic [15:0]           lfsr;
  logic [15:0]           rounds;
  logic [2:0]            r0, c0, r1, c1;
  logic [7:0][7:0]       mark;
  logic [6:0]            mark_cnt;
  logic                  any_empty;
  logic [7:0][7:0][2:0]  fall_nxt;
  logic                  adj;
  logic [16:0]           score_sum;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = (state == S_IDLE) && !wr_en;
  assign score_sum = {1'b0, score} + {10'b0, mark_cnt};

  // 4-bit compares so that 7+1 does not wrap onto 0.
  always_comb begin
    adj = ((cmd_r0 == cmd_r1) &&
           (({1'b0, cmd_c0} == {1'b0, cmd_c1} + 4'd1) || ({1'b0, cmd_c1} == {1'b0, cmd_c0} + 4'd1))) ||
          ((cmd_c0 == cmd_c1) &&
           (({1'b0, cmd_r0} == {1'b0, cmd_r1} + 4'd1) || ({1'b0, cmd_r1} == {1'b0, cmd_r0} + 4'd1)));
  end

  // Every cell covered by some equal non-empty triple lies in a run of >=3.
  always_comb begin
    mark = '0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 6; b++) begin
        if (board[a][b] != EMPTY && board[a][b] == board[a][b+1] && board[a][b] == board[a][b+2]) begin
          mark[a][b] = 1'b1; mark[a][b+1] = 1'b1; mark[a][b+2] = 1'b1;
        end
        if (board[b][a] != EMPTY && board[b][a] == board[b+1][a] && board[b][a] == board[b+2][a]) begin
          mark[b][a] = 1'b1; mark[b+1][a] = 1'b1; mark[b+2][a] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mark_cnt  = '0;
    any_empty = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        mark_cnt = mark_cnt + 7'(mark[r][c]);
        if (board[r][c] == EMPTY) any_empty = 1'b1;
      end
    end
  end

  // One gravity step: a non-empty cell above an empty one drops by one row.
  // Receiving and vacating are exclusive per cell, so the in-order update is
  // equivalent to a fully parallel step. Row 0 refills after the drop.
  always_comb begin
    fall_nxt = board;
    for (int c = 0; c < 8; c++) begin
      for (int r = 1; r < 8; r++) begin
        if (board[r][c] == EMPTY && board[r-1][c] != EMPTY) begin
          fall_nxt[r][c]   = board[r-1][c];
          fall_nxt[r-1][c] = EMPTY;
        end
      end
      if (fall_nxt[0][c] == EMPTY) fall_nxt[0][c] = 3'((int'(lfsr[2:0]) + c) % 6);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_INIT;
      score     <= '0;
      rounds    <= '0;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rd_color  <= '0;
      r0 <= '0; c0 <= '0; r1 <= '0; c1 <= '0;
      // (8r+c) mod 6 has no 3-run and no single swap creates one.
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r][c] <= 3'((8*r + c) % 6);
    end else begin
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      rd_color  <= board[rd_row][rd_col];
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            if (wr_color < 3'd6) board[wr_row][wr_col] <= wr_color;
          end else if (cmd_valid) begin
            if (adj) begin
              r0 <= cmd_r0; c0 <= cmd_c0; r1 <= cmd_r1; c1 <= cmd_c1;
              rounds <= '0;
              state  <= S_SWAP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_ok    <= 1'b0;
            end
          end
        end
        S_SWAP: begin
          board[r0][c0] <= board[r1][c1];
          board[r1][c1] <= board[r0][c0];
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (rounds == 16'(MAX_CASCADE)) begin
            state <= S_IDLE; rsp_valid <= 1'b1; rsp_ok <= 1'b1;
          end else if (mark_cnt == 7'd0) begin
            // rounds == 0 means this scan directly follows the swap.
            if (rounds == 16'd0) state <= S_UNDO;
            else begin
              state <= S_IDLE; rsp_valid <= 1'b1; rsp_ok <= 1'b1;
            end
          end else begin
            state <= S_CLEAR;
          end
        end
        S_UNDO: begin
          board[r0][c0] <= board[r1][c1];
          board[r1][c1] <= board[r0][c0];
          state <= S_IDLE; rsp_valid <= 1'b1; rsp_ok <= 1'b0;
        end
        S_CLEAR: begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              if (mark[r][c]) board[r][c] <= EMPTY;
          score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          rounds <= rounds + 16'd1;
          state  <= S_FALL;
        end
        S_FALL: begin
          if (any_empty) board <= fall_nxt;
          else           state <= S_SCAN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: randomized scoreboard bench for board_engine. Stimulus
// pushes expected responses / read values; a negedge monitor pops and compares.
module tb_board_engine;
  logic        clk = 1'b0, clrn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_r0 = '0, cmd_c0 = '0, cmd_r1 = '0, cmd_c1 = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0, wr_col = '0, wr_color = '0;
  logic [2:0]  rd_row = '0, rd_col = '0, rd_color;
  logic        rsp_valid, rsp_ok, busy;
  logic [15:0] score;

  localparam int MAXC = 16;

  board_engine #(.SEED(16'hACE1), .MAX_CASCADE(MAXC)) dut (
    .clk(clk), .clrn(clrn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r0(cmd_r0), .cmd_c0(cmd_c0), .cmd_r1(cmd_r1), .cmd_c1(cmd_c1),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color),
    .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .busy(busy), .score(score));

  always #5 clk = ~clk;

  typedef struct { int ok; int sc; int due; } rsp_t;
  typedef struct { int col; int due; int r; int c; } rd_t;
  rsp_t rq[$];
  rd_t  dq[$];
  int checks = 0, passes = 0, cyc = 0;
  logic [15:0] m_lfsr;
  int mb[8][8];
  bit mk[8][8];
  int m_score;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: Fibonacci, taps 16,14,13,11, free running.
  always @(posedge clk or negedge clrn)
    if (!clrn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    rd_t  d;
    if (clrn) begin
      if (rsp_valid) begin
        if (rq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rsp_ok", int'(rsp_ok), e.ok);
          chk("rsp_score", int'(score), e.sc);
          chk("rsp_cycle", cyc, e.due);
        end
      end
      while (dq.size() > 0 && dq[0].due == cyc) begin
        d = dq.pop_front();
        chk($sformatf("rd[%0d][%0d]", d.r, d.c), int'(rd_color), d.col);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lf_at(input logic [15:0] x, input int k);
    logic [15:0] v = x;
    for (int i = 0; i < k; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[r][c] = (8*r + c) % 6;
    m_score = 0;
  endtask

  // Marks maximal runs of length >= 3 and returns how many cells are marked.
  task automatic m_scan(output int n);
    int len;
    n = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mk[r][c] = 0;
    for (int a = 0; a < 8; a++) begin
      for (int s = 0; s < 8; s += len) begin
        len = 1;
        while (s + len < 8 && mb[a][s+len] == mb[a][s]) len++;
        if (mb[a][s] != 7 && len >= 3) for (int k = 0; k < len; k++) mk[a][s+k] = 1;
      end
      for (int s = 0; s < 8; s += len) begin
        len = 1;
        while (s + len < 8 && mb[s+len][a] == mb[s][a]) len++;
        if (mb[s][a] != 7 && len >= 3) for (int k = 0; k < len; k++) mk[s+k][a] = 1;
      end
    end
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) n += int'(mk[r][c]);
  endtask

  function automatic bit m_has_empty();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) if (mb[r][c] == 7) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fall(input logic [15:0] lf);
    int old[8];
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) old[r] = mb[r][c];
      for (int r = 1; r < 8; r++)
        if (old[r] == 7 && old[r-1] != 7) begin mb[r][c] = old[r-1]; mb[r-1][c] = 7; end
      if (mb[0][c] == 7) mb[0][c] = (int'(lf[2:0]) + c) % 6;
    end
  endtask

  task automatic m_swap(input int r0, input int c0, input int r1, input int c1);
    int t = mb[r0][c0];
    mb[r0][c0] = mb[r1][c1];
    mb[r1][c1] = t;
  endtask

  // Plays one command from the acceptance cycle. off = cycles after the
  // accept edge at which rsp_valid is visible; cycle k sees lfsr = lf0 stepped k times.
  task automatic m_cmd(input int r0, input int c0, input int r1, input int c1,
                       input logic [15:0] lf0, output int ok, output int off);
    int dr, dc, k, rounds, n;
    dr = (r0 > r1) ? r0 - r1 : r1 - r0;
    dc = (c0 > c1) ? c0 - c1 : c1 - c0;
    if (dr + dc != 1) begin ok = 0; off = 0; return; end
    m_swap(r0, c0, r1, c1);
    k = 1; rounds = 0;
    forever begin
      if (rounds == MAXC) begin ok = 1; off = k + 1; break; end
      m_scan(n);
      if (n == 0) begin
        if (rounds == 0) begin m_swap(r0, c0, r1, c1); ok = 0; off = k + 2; end
        else begin ok = 1; off = k + 1; end
        break;
      end
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) if (mk[r][c]) mb[r][c] = 7;
      m_score = (m_score + n > 65535) ? 65535 : m_score + n;
      rounds++;
      k += 2;
      while (m_has_empty()) begin m_fall(lf_at(lf0, k)); k++; end
      k++;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset(input int ncyc);
    clrn = 1'b0; cmd_valid = 1'b0; wr_en = 1'b0;
    rq.delete(); dq.delete();
    m_reset();
    repeat (ncyc) @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_ok", int'(rsp_ok), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_color", int'(rd_color), 0);
    chk("reset_score", int'(score), 0);
    clrn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", int'(cmd_ready), 1);
    @(negedge clk);
  endtask

  task automatic wr(input int r, input int c, input int col);
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_color = 3'(col);
    @(negedge clk);
    wr_en = 1'b0;
    if (col < 6) mb[r][c] = col;
  endtask

  task automatic readall();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c);
        dq.push_back('{mb[r][c], cyc + 1, r, c});
        @(negedge clk);
      end
    @(negedge clk);
  endtask

  // hold: keep cmd_valid and wr_en asserted while busy. abort >= 0: return
  // at that many cycles after acceptance without waiting for the response.
  task automatic cmd(input int r0, input int c0, input int r1, input int c1,
                     input bit hold, input int abort);
    int ok, off, t, n;
    logic [15:0] lf;
    cmd_r0 = 3'(r0); cmd_c0 = 3'(c0); cmd_r1 = 3'(r1); cmd_c1 = 3'(c1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc; lf = m_lfsr;
    if (hold) begin wr_en = 1'b1; wr_row = 3'(r0); wr_col = 3'(c0); wr_color = 3'($urandom_range(0, 5)); end
    else cmd_valid = 1'b0;
    m_cmd(r0, c0, r1, c1, lf, ok, off);
    rq.push_back('{ok, m_score, t + off});
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (i == abort) begin chk("busy_before_abort", int'(busy), 1); return; end
      if (busy) begin
        n++;
        if (hold) chk("ready_while_busy", int'(cmd_ready), 0);
      end else begin
        cmd_valid = 1'b0; wr_en = 1'b0;
        if (rq.size() == 0) break;
      end
    end
    cmd_valid = 1'b0; wr_en = 1'b0;
    if (rq.size() != 0) begin chk("rsp_timeout", rq.size(), 0); rq.delete(); end
    chk("busy_cycles", n, off);
  endtask

  initial begin
    int r0, c0, r1, c1;
    @(negedge clk);
    do_reset(3);

    readall();                           // reset pattern
    cmd(0, 0, 0, 2, 1'b0, -1);           // non-adjacent: reject at T+1
    cmd(3, 3, 3, 3, 1'b0, -1);           // same cell: reject
    readall();
    cmd(0, 0, 0, 1, 1'b0, -1);           // adjacent, no match: undone
    readall();
    wr(0, 0, 3); wr(0, 1, 3);
    cmd(0, 2, 0, 3, 1'b0, -1);           // makes 3,3,3: kept
    readall();
    cmd(4, 4, 5, 4, 1'b1, -1);           // cmd/wr held while busy
    readall();

    for (int it = 0; it < 25; it++) begin
      repeat (4) wr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      r0 = $urandom_range(0, 7); c0 = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) begin
        r1 = r0; c1 = c0;
        case ($urandom_range(0, 3))
          0: r1 = (r0 == 7) ? 6 : r0 + 1;
          1: r1 = (r0 == 0) ? 1 : r0 - 1;
          2: c1 = (c0 == 7) ? 6 : c0 + 1;
          default: c1 = (c0 == 0) ? 1 : c0 - 1;
        endcase
        cmd(r0, c0, r1, c1, (it % 5) == 0, -1);
      end else begin
        r1 = $urandom_range(0, 7); c1 = $urandom_range(0, 7);
        if ((r0 - r1) * (r0 - r1) + (c0 - c1) * (c0 - c1) == 1) r1 = r0 ^ 4;
        cmd(r0, c0, r1, c1, 1'b0, -1);
      end
      readall();
    end

    // Reset pulse in the middle of FALL (cycle T+3 after acceptance).
    do_reset(2);
    wr(0, 0, 3); wr(0, 1, 3);
    cmd(0, 2, 0, 3, 1'b0, 3);
    do_reset(2);
    repeat (5) @(negedge clk);
    chk("idle_after_midop_reset", int'(busy), 0);
    readall();

    // Saturation: preset close to the top, then repeated full-board matches.
    force dut.score = 16'hFFD0;
    @(negedge clk);
    release dut.score;
    m_score = 16'hFFD0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) wr(r, c, 2);
      cmd(0, 0, 0, 1, 1'b0, -1);
      chk("score_saturated", int'(score), 65535);
    end
    readall();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule
